// File: rtl/multdiv_iter_if.sv
// Handshake/bus bundle between the execute-stage control and the iterative mul/div unit.
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply / restoring divide feeding the EX/MEM latch.
// Define MULTDIV_RADIX4_EN for a radix-4 Booth multiply (WIDTH/2 iterations).
//
// state  | meaning
// IDLE   | waiting for ctrl_MULT / ctrl_DIV
// MUL    | one multiply iteration per cycle
// DIV    | one restoring-divide iteration per cycle
// DONE   | sign fix, register result/exception, pulse RDY
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  multdiv_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_x;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_y;
  logic               r_neg;
  logic               r_is_div;
  logic               r_bzero;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;
  logic               r_busy;

  logic               w_start;
  logic               w_sign_diff;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [2*WIDTH-1:0] w_mul_x;
  logic [WIDTH-1:0]   w_mul_y;
  logic [2*WIDTH-1:0] w_mul_x0;
  logic [WIDTH-1:0]   w_mul_y0;
  logic               w_mul_neg0;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mag_res;
  logic [2*WIDTH-1:0] w_signed;
  logic [WIDTH-1:0]   w_done_res;
  logic               w_done_exc;

  assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_sign_diff = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
  assign w_mag_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign w_mag_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_RADIX4_EN
  localparam int N_MUL = WIDTH / 2;

  logic r_bprev;

  // Booth works on the raw two's-complement operands, so no sign fix is needed later.
  always_comb begin
    w_pp = '0;
    case ({r_y[1:0], r_bprev})
      3'b001, 3'b010: w_pp = r_x;
      3'b011:         w_pp = r_x << 1;
      3'b100:         w_pp = -(r_x << 1);
      3'b101, 3'b110: w_pp = -r_x;
      default:        w_pp = '0;
    endcase
  end

  assign w_mul_x0   = {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
  assign w_mul_y0   = bus.data_operandB;
  assign w_mul_neg0 = 1'b0;
  assign w_mul_x    = r_x << 2;
  assign w_mul_y    = {2'b00, r_y[WIDTH-1:2]};
`else
  localparam int N_MUL = WIDTH;

  assign w_pp       = r_y[0] ? r_x : '0;
  assign w_mul_x0   = {{WIDTH{1'b0}}, w_mag_a};
  assign w_mul_y0   = w_mag_b;
  assign w_mul_neg0 = w_sign_diff;
  assign w_mul_x    = r_x << 1;
  assign w_mul_y    = {1'b0, r_y[WIDTH-1:1]};
`endif

  localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  assign w_mul_acc = r_acc + w_pp;

  // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
  assign w_rem_sh = {r_acc[WIDTH-1:0], r_y[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_x[WIDTH-1:0]};

  assign w_mag_res = r_is_div ? {{WIDTH{1'b0}}, r_y} : r_acc;
  assign w_signed  = r_neg ? -w_mag_res : w_mag_res;

  always_comb begin
    w_done_res = w_signed[WIDTH-1:0];
    w_done_exc = 1'b0;
    if (r_is_div) begin
      if (r_bzero) begin
        w_done_res = '0;
        w_done_exc = 1'b1;
      end else begin
        // Only a positive quotient of 2^(WIDTH-1) (MIN / -1) fails to fit.
        w_done_exc = r_y[WIDTH-1] & ~r_neg;
      end
    end else begin
      w_done_exc = (w_signed[2*WIDTH-1:WIDTH-1] != '0) &&
                   (w_signed[2*WIDTH-1:WIDTH-1] != '1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_is_div <= 1'b0;
      r_bzero  <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
      r_bprev  <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_busy  <= 1'b1;
        r_bzero <= (bus.data_operandB == '0);
`ifdef MULTDIV_RADIX4_EN
        r_bprev <= 1'b0;
`endif
        if (bus.ctrl_MULT) begin
          r_state  <= S_MUL;
          r_is_div <= 1'b0;
          r_x      <= w_mul_x0;
          r_y      <= w_mul_y0;
          r_neg    <= w_mul_neg0;
        end else begin
          r_state  <= S_DIV;
          r_is_div <= 1'b1;
          r_x      <= {{WIDTH{1'b0}}, w_mag_b};
          r_y      <= w_mag_a;
          r_neg    <= w_sign_diff;
        end
      end else begin
        case (r_state)
          S_MUL: begin
            r_acc <= w_mul_acc;
            r_x   <= w_mul_x;
            r_y   <= w_mul_y;
`ifdef MULTDIV_RADIX4_EN
            r_bprev <= r_y[1];
`endif
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == MUL_LAST) begin
              r_state <= S_DONE;
              r_cnt   <= '0;
            end
          end
          S_DIV: begin
            if (!w_diff[WIDTH]) begin
              r_acc <= {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
              r_y   <= {r_y[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_rem_sh[WIDTH-1:0]};
              r_y   <= {r_y[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == DIV_LAST) begin
              r_state <= S_DONE;
              r_cnt   <= '0;
            end
          end
          S_DONE: begin
            r_result <= w_done_res;
            r_exc    <= w_done_exc;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed table, abort/reset sequences, random ops vs. arithmetic model.
module tb_multdiv_iter;

`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  multdiv_iter_if #(.WIDTH(32)) bus ();

  multdiv_iter #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Signed 64-bit arithmetic stands in for the iterative datapath.
  function automatic logic [32:0] ref_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     lo;
    int     sa;
    int     sb;
    int     q;
    sa = a;
    sb = b;
    if (is_mul) begin
      p  = longint'(sa) * longint'(sb);
      lo = int'(p);
      return {(p != longint'(lo)), 32'(lo)};
    end
    if (sb == 0) return {1'b1, 32'h0};
    if (sa == 32'sh80000000 && sb == -1) return {1'b1, 32'h80000000};
    q = sa / sb;
    return {1'b0, 32'(q)};
  endfunction

  task automatic issue_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic expect_done(input int exp_lat, input logic [31:0] er, input bit ee, input string tag);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.data_resultRDY) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy during op"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, 64'(bus.data_result), 64'(er));
    check({tag, " exception"}, 64'(bus.data_exception), 64'(ee));
    check({tag, " busy at rdy"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " rdy one cycle"}, 64'(bus.data_resultRDY), 64'd0);
  endtask

  initial begin
    bit          no_rdy;
    bit          idle_ok;
    bit          m;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;

    tbl[0]  = '{1, 0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 0};
    tbl[1]  = '{1, 0, 32'h00010000,  32'h00010000, 32'h00000000, 1};
    tbl[2]  = '{1, 0, 32'h80000000,  32'd1,        32'h80000000, 0};
    tbl[3]  = '{0, 1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 0};
    tbl[4]  = '{0, 1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 0};
    tbl[5]  = '{0, 1, 32'd5,         32'd0,        32'h00000000, 1};
    tbl[6]  = '{0, 1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    tbl[7]  = '{1, 1, 32'd6,         32'd3,        32'd18,       0};
    tbl[8]  = '{1, 0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    tbl[9]  = '{0, 1, 32'h80000000,  32'd1,        32'h80000000, 0};
    tbl[10] = '{1, 0, 32'd0,         32'hFFFFFFFF, 32'h00000000, 0};
    tbl[11] = '{0, 1, 32'hFFFFFFFD,  32'd7,        32'h00000000, 0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus.data_result, 29'd0, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      issue_start(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b);
      expect_done(tbl[i].m ? MUL_LAT : DIV_LAT, tbl[i].er, tbl[i].ee, $sformatf("vec%0d", i));
    end

    repeat (5) @(negedge clk);
    check("result hold", {31'd0, bus.data_exception, bus.data_result}, 64'h0);

    // Multiply aborted by a divide start: only the divide may complete.
    issue_start(1, 0, 32'd3, 32'd4);
    no_rdy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.data_resultRDY) no_rdy = 1'b0;
    end
    check("abort no early rdy", 64'(no_rdy), 64'd1);
    issue_start(0, 1, 32'd100, 32'd7);
    expect_done(DIV_LAT, 32'd14, 1'b0, "abort div");

    // Reset mid-divide.
    issue_start(0, 1, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("midop reset outputs", {bus.data_result, 29'd0, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    idle_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.data_resultRDY || bus.busy) idle_ok = 1'b0;
    end
    check("post reset idle", 64'(idle_ok), 64'd1);
    issue_start(1, 0, 32'd2, 32'd2);
    expect_done(MUL_LAT, 32'd4, 1'b0, "post reset mul");

    for (int n = 0; n < 40; n++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) a = a >>> $urandom_range(8, 24);
      exp = ref_model(m, a, b);
      issue_start(m, !m, a, b);
      expect_done(m ? MUL_LAT : DIV_LAT, exp[31:0], exp[32], $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
